// File: rtl/enigma_pkg.sv
// enigma_pkg: rotor wiring/notch tables and letter helpers shared by the rotor datapath.
package enigma_pkg;

    typedef enum logic [2:0] {ROTOR_I, ROTOR_II, ROTOR_III, ROTOR_IV, ROTOR_V} rotor_e;

    localparam int LETTERS = 26;

    typedef logic [4:0] letter_t;

    localparam int WIRING [5][LETTERS] = '{
        '{4, 10, 12, 5, 11, 6, 3, 16, 21, 25, 13, 19, 14, 22, 24, 7, 23, 20, 18, 15, 0, 8, 1, 17, 2, 9},
        '{0, 9, 3, 10, 18, 8, 17, 20, 23, 1, 11, 7, 22, 19, 12, 2, 16, 6, 25, 13, 15, 24, 5, 21, 14, 4},
        '{1, 3, 5, 7, 9, 11, 2, 15, 17, 19, 23, 21, 25, 13, 24, 4, 8, 22, 6, 0, 10, 12, 20, 18, 16, 14},
        '{4, 18, 14, 21, 15, 25, 9, 0, 24, 16, 20, 8, 17, 7, 23, 11, 13, 5, 19, 6, 10, 3, 2, 12, 22, 1},
        '{21, 25, 1, 17, 6, 8, 19, 24, 20, 15, 18, 3, 13, 7, 11, 23, 0, 22, 12, 9, 16, 14, 5, 4, 2, 10}
    };

    localparam int WIRING_INV [5][LETTERS] = '{
        '{20, 22, 24, 6, 0, 3, 5, 15, 21, 25, 1, 4, 2, 10, 12, 19, 7, 23, 18, 11, 17, 8, 13, 16, 14, 9},
        '{0, 9, 15, 2, 25, 22, 17, 11, 5, 1, 3, 10, 14, 19, 24, 20, 16, 6, 4, 13, 7, 23, 12, 8, 21, 18},
        '{19, 0, 6, 1, 15, 2, 18, 3, 16, 4, 20, 5, 21, 13, 25, 7, 24, 8, 23, 9, 22, 11, 17, 10, 14, 12},
        '{7, 25, 22, 21, 0, 17, 19, 13, 11, 6, 20, 15, 23, 16, 2, 4, 9, 12, 1, 18, 10, 3, 24, 14, 8, 5},
        '{16, 2, 24, 11, 23, 22, 4, 13, 5, 19, 25, 14, 18, 12, 21, 9, 20, 3, 10, 6, 8, 0, 17, 15, 7, 1}
    };

    localparam int NOTCH [5] = '{16, 4, 21, 9, 25};

    function automatic letter_t onehot_to_idx(input logic [LETTERS-1:0] v);
        letter_t r = '0;
        for (int i = 0; i < LETTERS; i++)
            if (v[i]) r = letter_t'(i);
        return r;
    endfunction

    function automatic logic [LETTERS-1:0] idx_to_onehot(input letter_t i);
        return (i < 5'd26) ? (26'd1 << i) : '0;
    endfunction

    function automatic letter_t mod26_add(input letter_t a, input letter_t b);
        logic [5:0] s;
        s = {1'b0, a} + {1'b0, b};
        return letter_t'((s >= 6'd26) ? s - 6'd26 : s);
    endfunction

endpackage

// File: rtl/rotor_perm.sv
// rotor_perm: combinational one-hot letter permutation through a rotor at a given offset.
module rotor_perm
    import enigma_pkg::*;
#(
    parameter rotor_e ROTOR_SEL = ROTOR_I
) (
    input  logic          inv,
    input  letter_t       off,
    input  logic [25:0]   din,
    output logic [25:0]   dout
);

    letter_t t;
    letter_t w;
    letter_t back;

    always_comb begin
        t    = mod26_add(onehot_to_idx(din), off);
        w    = inv ? letter_t'(WIRING_INV[ROTOR_SEL][t]) : letter_t'(WIRING[ROTOR_SEL][t]);
        back = mod26_add(w, (off == '0) ? '0 : letter_t'(5'd26 - off));
        dout = $onehot(din) ? idx_to_onehot(back) : '0;
    end

endmodule

// File: rtl/rotor_stage.sv
// rotor_stage: one stepping Enigma rotor with registered forward and reverse letter paths.
module rotor_stage
    import enigma_pkg::*;
#(
    parameter rotor_e ROTOR_SEL = ROTOR_I
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        LOAD,
    input  logic [4:0]  POS_IN,
    input  logic [4:0]  RING_IN,
    input  logic        STEP_IN,
    output logic        STEP_OUT,
    output logic [4:0]  POS_OUT,
    input  logic        FWD_VALID_IN,
    input  logic [25:0] FWD_IN,
    output logic        FWD_VALID_OUT,
    output logic [25:0] FWD_OUT,
    input  logic        REV_VALID_IN,
    input  logic [25:0] REV_IN,
    output logic        REV_VALID_OUT,
    output logic [25:0] REV_OUT,
    output logic        ERR
);

    letter_t     pos;
    letter_t     ring;
    letter_t     pos_nxt;
    letter_t     ring_nxt;
    letter_t     off;
    logic [5:0]  diff;
    logic        err_set;
    logic [25:0] fwd_perm;
    logic [25:0] rev_perm;

    // Letters are encoded against the position the rotor holds after this cycle's load/step.
    always_comb begin
        pos_nxt  = LOAD ? ((POS_IN > 5'd25) ? '0 : POS_IN)
                 : STEP_IN ? ((pos == 5'd25) ? '0 : pos + 5'd1) : pos;
        ring_nxt = LOAD ? ((RING_IN > 5'd25) ? '0 : RING_IN) : ring;
        diff     = {1'b0, pos_nxt} - {1'b0, ring_nxt};
        off      = letter_t'(diff[5] ? diff + 6'd26 : diff);
        err_set  = (LOAD & ((POS_IN > 5'd25) | (RING_IN > 5'd25)))
                 | (FWD_VALID_IN & ~$onehot(FWD_IN))
                 | (REV_VALID_IN & ~$onehot(REV_IN));
    end

    assign STEP_OUT = STEP_IN & ~LOAD & (pos == letter_t'(NOTCH[ROTOR_SEL]));
    assign POS_OUT  = pos;

    rotor_perm #(.ROTOR_SEL(ROTOR_SEL)) u_fwd (
        .inv  (1'b0),
        .off  (off),
        .din  (FWD_IN),
        .dout (fwd_perm)
    );

    rotor_perm #(.ROTOR_SEL(ROTOR_SEL)) u_rev (
        .inv  (1'b1),
        .off  (off),
        .din  (REV_IN),
        .dout (rev_perm)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pos           <= '0;
            ring          <= '0;
            FWD_VALID_OUT <= 1'b0;
            FWD_OUT       <= '0;
            REV_VALID_OUT <= 1'b0;
            REV_OUT       <= '0;
            ERR           <= 1'b0;
        end else begin
            pos           <= pos_nxt;
            ring          <= ring_nxt;
            FWD_VALID_OUT <= FWD_VALID_IN;
            FWD_OUT       <= FWD_VALID_IN ? fwd_perm : '0;
            REV_VALID_OUT <= REV_VALID_IN;
            REV_OUT       <= REV_VALID_IN ? rev_perm : '0;
            ERR           <= ERR | err_set;
        end
    end

endmodule
